// File: rtl/nanocache_refill_pkg.sv
// Shared line geometry and record types for the nanocache refill engine.
// Line size and address width are fixed here so structs and the bus interface agree.
package nanocache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int ADDR_W     = 32;
    localparam int LINE_W     = LINE_WORDS * 32;
    localparam int STRB_W     = LINE_WORDS * 4;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } refill_req_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              drop;
    } outst_t;

endpackage

// File: rtl/nanocache_refill_if.sv
// Memory-arbiter side bus of the refill engine (master = engine, slave = arbiter).
interface nanocache_refill_if;
    import nanocache_pkg::*;

    // Handshake: a request (rden or wren with addr/wdata/wstrb) is held stable
    // until the cycle gnt is high; that cycle transfers it. rvalid/rdata return
    // one read line per pulse, in grant order, with no back-pressure.
    logic              rden;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              gnt;
    logic              rvalid;
    logic [LINE_W-1:0] rdata;

    modport master (
        output rden, wren, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  rden, wren, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/nanocache_sync_fifo.sv
// Shift-register FIFO (head always at slot 0) with a per-slot kill mask.
// DISCARD=1 removes killed slots; DISCARD=0 keeps them and flags them as killed.
module nanocache_sync_fifo #(
    parameter type      T       = logic,
    parameter int       DEPTH   = 2,
    parameter bit       DISCARD = 1'b1,
    localparam int      CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  T                 i_din,
    input  logic             i_pop,
    input  logic [DEPTH-1:0] i_kill,
    output T                 o_head,
    output logic             o_head_killed,
    output T                 o_mem [DEPTH],
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    T                 r_mem [DEPTH];
    logic [DEPTH-1:0] r_killed;
    logic [CNT_W-1:0] r_cnt;

    T                 w_nxt_mem [DEPTH];
    logic [DEPTH-1:0] w_nxt_killed;
    logic [CNT_W-1:0] w_nxt_cnt;

    // Survivors are compacted towards slot 0, then the pushed entry lands behind them.
    always_comb begin
        int pos;
        w_nxt_mem    = r_mem;
        w_nxt_killed = '0;
        pos          = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((i < int'(r_cnt)) && !(i_pop && (i == 0)) && !(DISCARD && i_kill[i])) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == pos) begin
                        w_nxt_mem[j]    = r_mem[i];
                        w_nxt_killed[j] = r_killed[i] | i_kill[i];
                    end
                end
                pos++;
            end
        end
        if (i_push && (pos < DEPTH)) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j == pos) w_nxt_mem[j] = i_din;
            end
            pos++;
        end
        w_nxt_cnt = CNT_W'(pos);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_killed <= '0;
        end else begin
            r_cnt    <= w_nxt_cnt;
            r_killed <= w_nxt_killed;
        end
    end

    always_ff @(posedge i_clk) begin
        r_mem <= w_nxt_mem;
    end

    always_comb begin
        o_mem = r_mem;
    end

    assign o_head        = r_mem[0];
    assign o_head_killed = r_killed[0];
    assign o_full        = (r_cnt == CNT_W'(DEPTH));
    assign o_empty       = (r_cnt == '0);
    assign o_count       = r_cnt;

endmodule

// File: rtl/nanocache_refill.sv
// Cache miss/refill engine: in-order request queue, outstanding-read tracker, flush.
// Define NANOCACHE_REFILL_STATS_EN to add o_stat_rd / o_stat_wr / o_stat_drop counters.
module nanocache_refill
    import nanocache_pkg::*;
#(
    parameter int REQ_DEPTH = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_miss_rden,
    input  logic              i_miss_wren,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic [LINE_W-1:0] i_miss_wdata,
    input  logic [STRB_W-1:0] i_miss_wstrb,
    output logic              o_miss_ready,
    nanocache_refill_if.master mm_if,
    output logic              o_upd_valid,
    output logic [LINE_W-1:0] o_upd_rdata,
    output logic [ADDR_W-1:0] o_upd_addr,
    output logic              o_busy,
    output logic              o_err
`ifdef NANOCACHE_REFILL_STATS_EN
    ,
    output logic [31:0]       o_stat_rd,
    output logic [31:0]       o_stat_wr,
    output logic [31:0]       o_stat_drop
`endif
);

    refill_req_t                  w_q_din, w_q_head;
    refill_req_t                  w_q_mem [REQ_DEPTH];
    logic                         w_q_push, w_q_pop, w_q_full, w_q_empty, w_q_head_killed;
    logic [REQ_DEPTH-1:0]         w_q_kill;
    logic [$clog2(REQ_DEPTH):0]   w_q_cnt;

    outst_t                       w_t_din, w_t_head;
    outst_t                       w_t_mem_unused [MAX_OUTST];
    logic                         w_t_push, w_t_pop, w_t_full, w_t_empty, w_t_head_killed;
    logic [MAX_OUTST-1:0]         w_t_kill;
    logic [$clog2(MAX_OUTST):0]   w_t_cnt;

    logic w_pres_rd, w_pres_wr, w_gnt, w_drop, w_unused;
    logic r_head_drop, r_err, r_upd_valid;
    logic [LINE_W-1:0] r_upd_rdata;
    logic [ADDR_W-1:0] r_upd_addr;

    assign w_unused = ^{w_q_cnt, w_q_head_killed, w_t_cnt};

    // A simultaneous read+write is queued as the write alone.
    assign o_miss_ready = ~w_q_full;
    assign w_q_push     = (i_miss_rden | i_miss_wren) & ~w_q_full;
    assign w_q_din      = '{wr: i_miss_wren, addr: i_miss_addr, wdata: i_miss_wdata, wstrb: i_miss_wstrb};

    assign w_pres_wr = ~w_q_empty & w_q_head.wr;
    assign w_pres_rd = ~w_q_empty & ~w_q_head.wr & ~w_t_full;
    assign w_gnt     = mm_if.gnt & (w_pres_rd | w_pres_wr);
    assign w_q_pop   = w_gnt;

    always_comb begin
        for (int i = 0; i < REQ_DEPTH; i++) begin
            w_q_kill[i] = i_flush & ~w_q_mem[i].wr & ~((i == 0) & w_pres_rd);
        end
    end

    nanocache_sync_fifo #(.T(refill_req_t), .DEPTH(REQ_DEPTH), .DISCARD(1'b1)) u_req_q (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(w_q_push), .i_din(w_q_din), .i_pop(w_q_pop),
        .i_kill(w_q_kill), .o_head(w_q_head), .o_head_killed(w_q_head_killed), .o_mem(w_q_mem),
        .o_full(w_q_full), .o_empty(w_q_empty), .o_count(w_q_cnt)
    );

    // A read still on the bus when flush hits is issued, but its response is discarded.
    assign w_t_push = w_gnt & w_pres_rd;
    assign w_t_din  = '{addr: w_q_head.addr, drop: i_flush | r_head_drop};
    assign w_t_pop  = mm_if.rvalid & ~w_t_empty;
    assign w_t_kill = {MAX_OUTST{i_flush}};
    assign w_drop   = w_t_head.drop | w_t_head_killed | i_flush;

    nanocache_sync_fifo #(.T(outst_t), .DEPTH(MAX_OUTST), .DISCARD(1'b0)) u_tracker (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(w_t_push), .i_din(w_t_din), .i_pop(w_t_pop),
        .i_kill(w_t_kill), .o_head(w_t_head), .o_head_killed(w_t_head_killed), .o_mem(w_t_mem_unused),
        .o_full(w_t_full), .o_empty(w_t_empty), .o_count(w_t_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head_drop <= 1'b0;
            r_err       <= 1'b0;
            r_upd_valid <= 1'b0;
            r_upd_rdata <= '0;
            r_upd_addr  <= '0;
        end else begin
            if (w_q_pop)                    r_head_drop <= 1'b0;
            else if (i_flush && w_pres_rd)  r_head_drop <= 1'b1;
            r_err       <= r_err | (w_q_push & i_miss_rden & i_miss_wren) | (mm_if.rvalid & w_t_empty);
            r_upd_valid <= w_t_pop & ~w_drop;
            if (w_t_pop && !w_drop) begin
                r_upd_rdata <= mm_if.rdata;
                r_upd_addr  <= w_t_head.addr;
            end
        end
    end

    assign mm_if.rden  = w_pres_rd;
    assign mm_if.wren  = w_pres_wr;
    assign mm_if.addr  = (w_pres_rd | w_pres_wr) ? w_q_head.addr : '0;
    assign mm_if.wdata = w_pres_wr ? w_q_head.wdata : '0;
    assign mm_if.wstrb = w_pres_wr ? w_q_head.wstrb : '0;

    assign o_upd_valid = r_upd_valid;
    assign o_upd_rdata = r_upd_rdata;
    assign o_upd_addr  = r_upd_addr;
    assign o_busy      = ~w_q_empty | ~w_t_empty;
    assign o_err       = r_err;

`ifdef NANOCACHE_REFILL_STATS_EN
    logic [31:0] r_stat_rd, r_stat_wr, r_stat_drop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_rd   <= '0;
            r_stat_wr   <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_t_push)              r_stat_rd   <= r_stat_rd + 32'd1;
            if (w_gnt && w_pres_wr)    r_stat_wr   <= r_stat_wr + 32'd1;
            if (w_t_pop && w_drop)     r_stat_drop <= r_stat_drop + 32'd1;
        end
    end

    assign o_stat_rd   = r_stat_rd;
    assign o_stat_wr   = r_stat_wr;
    assign o_stat_drop = r_stat_drop;
`endif

endmodule

// File: tb/tb_nanocache_refill.sv
// Directed bench for nanocache_refill: one task per scenario, inline checks.
module tb_nanocache_refill;
    import nanocache_pkg::*;

    logic              clk = 1'b0;
    logic              rst, flush, miss_rden, miss_wren, miss_ready;
    logic [ADDR_W-1:0] miss_addr, upd_addr;
    logic [LINE_W-1:0] miss_wdata, upd_rdata;
    logic [STRB_W-1:0] miss_wstrb;
    logic              upd_valid, busy, err;
`ifdef NANOCACHE_REFILL_STATS_EN
    logic [31:0]       stat_rd, stat_wr, stat_drop;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nanocache_refill_if mm_if();

    nanocache_refill #(.REQ_DEPTH(2), .MAX_OUTST(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_miss_rden(miss_rden), .i_miss_wren(miss_wren), .i_miss_addr(miss_addr),
        .i_miss_wdata(miss_wdata), .i_miss_wstrb(miss_wstrb), .o_miss_ready(miss_ready),
        .mm_if(mm_if),
        .o_upd_valid(upd_valid), .o_upd_rdata(upd_rdata), .o_upd_addr(upd_addr),
        .o_busy(busy), .o_err(err)
`ifdef NANOCACHE_REFILL_STATS_EN
        , .o_stat_rd(stat_rd), .o_stat_wr(stat_wr), .o_stat_drop(stat_drop)
`endif
    );

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
        logic [LINE_W-1:0] r;
        for (int w = 0; w < LINE_WORDS; w++) r[w*32 +: 32] = base + 32'(w);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        miss_rden  = 1'b0;
        miss_wren  = 1'b0;
        miss_addr  = '0;
        miss_wdata = '0;
        miss_wstrb = '0;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [LINE_W-1:0] d, input logic [STRB_W-1:0] s);
        miss_rden  = rd;
        miss_wren  = wr;
        miss_addr  = a;
        miss_wdata = d;
        miss_wstrb = s;
    endtask

    task automatic drive_idle();
        clear_req();
        flush        = 1'b0;
        mm_if.gnt    = 1'b0;
        mm_if.rvalid = 1'b0;
        mm_if.rdata  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) cyc();
        rst = 1'b0;
        #2;
        checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", miss_ready); end
        checks++; if (mm_if.rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b exp 0", mm_if.rden); end
        checks++; if (mm_if.wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", mm_if.wren); end
        checks++; if (mm_if.addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mm_if.addr); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd got %b exp 0", upd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    endtask

    task automatic test_single_read();
        logic [LINE_W-1:0] line;
        line = mk_line(32'hD000_0000);
        set_req(1'b1, 1'b0, 32'h1000, '0, '0);
        cyc();
        clear_req();
        mm_if.gnt = 1'b1;
        #2;
        checks++; if (mm_if.rden !== 1'b1) begin errors++; $display("FAIL sr_rden got %b exp 1", mm_if.rden); end
        checks++; if (mm_if.addr !== 32'h1000) begin errors++; $display("FAIL sr_addr got %h exp 1000", mm_if.addr); end
        checks++; if (mm_if.wren !== 1'b0) begin errors++; $display("FAIL sr_wren got %b exp 0", mm_if.wren); end
        cyc();
        mm_if.gnt = 1'b0;
        #2;
        checks++; if (mm_if.rden !== 1'b0) begin errors++; $display("FAIL sr_rden_after_gnt got %b exp 0", mm_if.rden); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sr_busy got %b exp 1", busy); end
        cyc();
        cyc();
        mm_if.rvalid = 1'b1;
        mm_if.rdata  = line;
        #2;
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL sr_upd_early got %b exp 0", upd_valid); end
        cyc();
        mm_if.rvalid = 1'b0;
        mm_if.rdata  = '0;
        #2;
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL sr_upd got %b exp 1", upd_valid); end
        checks++; if (upd_addr !== 32'h1000) begin errors++; $display("FAIL sr_upd_addr got %h exp 1000", upd_addr); end
        checks++; if (upd_rdata !== line) begin errors++; $display("FAIL sr_upd_data got %h exp %h", upd_rdata, line); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sr_idle got %b exp 0", busy); end
        cyc();
        #2;
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL sr_upd_pulse got %b exp 0", upd_valid); end
    endtask

    task automatic test_outstanding();
        mm_if.gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_req(1'b1, 1'b0, 32'(32'h100 * (k + 1)), '0, '0);
            cyc();
        end
        clear_req();
        #2;
        checks++; if (mm_if.rden !== 1'b0) begin errors++; $display("FAIL os_blocked got %b exp 0", mm_if.rden); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL os_busy got %b exp 1", busy); end
        cyc();
        #2;
        checks++; if (mm_if.rden !== 1'b0) begin errors++; $display("FAIL os_blocked2 got %b exp 0", mm_if.rden); end
        mm_if.rvalid = 1'b1;
        mm_if.rdata  = mk_line(32'hE100);
        #2;
        checks++; if (mm_if.rden !== 1'b0) begin errors++; $display("FAIL os_blocked_rv got %b exp 0", mm_if.rden); end
        cyc();
        mm_if.rvalid = 1'b0;
        #2;
        checks++; if (mm_if.rden !== 1'b1) begin errors++; $display("FAIL os_fifth_rden got %b exp 1", mm_if.rden); end
        checks++; if (mm_if.addr !== 32'h500) begin errors++; $display("FAIL os_fifth_addr got %h exp 500", mm_if.addr); end
        checks++; if (upd_valid !== 1'b1 || upd_addr !== 32'h100) begin errors++; $display("FAIL os_upd0 got %b/%h exp 1/100", upd_valid, upd_addr); end
        cyc();
        mm_if.gnt = 1'b0;
        for (int k = 1; k < 5; k++) begin
            mm_if.rvalid = 1'b1;
            mm_if.rdata  = mk_line(32'(32'hE100 + 32'h100 * k));
            cyc();
            mm_if.rvalid = 1'b0;
            #2;
            checks++;
            if (upd_valid !== 1'b1 || upd_addr !== 32'(32'h100 * (k + 1)) || upd_rdata !== mk_line(32'(32'hE100 + 32'h100 * k))) begin
                errors++; $display("FAIL os_upd%0d got %b/%h exp 1/%h", k, upd_valid, upd_addr, 32'h100 * (k + 1));
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL os_drained got %b exp 0", busy); end
        mm_if.rdata = '0;
    endtask

    task automatic test_wr_then_rd();
        logic [LINE_W-1:0] wd;
        wd = mk_line(32'hA000_0000);
        set_req(1'b0, 1'b1, 32'h2000, wd, 32'hF0F0_1234);
        cyc();
        set_req(1'b1, 1'b0, 32'h2000, '0, '0);
        #2;
        checks++; if (mm_if.wren !== 1'b1 || mm_if.rden !== 1'b0) begin errors++; $display("FAIL wr_first got w%b r%b exp w1 r0", mm_if.wren, mm_if.rden); end
        checks++; if (mm_if.addr !== 32'h2000) begin errors++; $display("FAIL wr_addr got %h exp 2000", mm_if.addr); end
        checks++; if (mm_if.wdata !== wd) begin errors++; $display("FAIL wr_wdata got %h exp %h", mm_if.wdata, wd); end
        checks++; if (mm_if.wstrb !== 32'hF0F0_1234) begin errors++; $display("FAIL wr_wstrb got %h exp f0f01234", mm_if.wstrb); end
        cyc();
        clear_req();
        #2;
        checks++; if (mm_if.wren !== 1'b1 || mm_if.rden !== 1'b0) begin errors++; $display("FAIL wr_hold got w%b r%b exp w1 r0", mm_if.wren, mm_if.rden); end
        checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL wr_q_full got %b exp 0", miss_ready); end
        mm_if.gnt = 1'b1;
        cyc();
        mm_if.gnt = 1'b0;
        #2;
        checks++; if (mm_if.wren !== 1'b0 || mm_if.rden !== 1'b1) begin errors++; $display("FAIL rd_after_wr got w%b r%b exp w0 r1", mm_if.wren, mm_if.rden); end
        checks++; if (mm_if.wdata !== '0) begin errors++; $display("FAIL rd_wdata got %h exp 0", mm_if.wdata); end
        mm_if.gnt = 1'b1;
        cyc();
        mm_if.gnt    = 1'b0;
        mm_if.rvalid = 1'b1;
        mm_if.rdata  = mk_line(32'hF200);
        cyc();
        mm_if.rvalid = 1'b0;
        mm_if.rdata  = '0;
        #2;
        checks++; if (upd_valid !== 1'b1 || upd_addr !== 32'h2000) begin errors++; $display("FAIL wr_rd_upd got %b/%h exp 1/2000", upd_valid, upd_addr); end
    endtask

    task automatic test_flush();
        logic [LINE_W-1:0] wd;
        wd = mk_line(32'hB000_0000);
        mm_if.gnt = 1'b1;
        set_req(1'b1, 1'b0, 32'h3000, '0, '0);
        cyc();
        set_req(1'b1, 1'b0, 32'h3100, '0, '0);
        cyc();
        set_req(1'b0, 1'b1, 32'h3300, wd, 32'h0000_FFFF);
        cyc();
        mm_if.gnt = 1'b0;
        set_req(1'b1, 1'b0, 32'h3200, '0, '0);
        cyc();
        clear_req();
        #2;
        checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL fl_full got %b exp 0", miss_ready); end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #2;
        checks++; if (mm_if.wren !== 1'b1 || mm_if.addr !== 32'h3300) begin errors++; $display("FAIL fl_wr_kept got %b/%h exp 1/3300", mm_if.wren, mm_if.addr); end
        checks++; if (mm_if.wdata !== wd || mm_if.wstrb !== 32'h0000_FFFF) begin errors++; $display("FAIL fl_wr_data got %h/%h", mm_if.wdata, mm_if.wstrb); end
        checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL fl_rd_removed got %b exp 1", miss_ready); end
        mm_if.gnt = 1'b1;
        cyc();
        mm_if.gnt = 1'b0;
        #2;
        checks++; if (mm_if.rden !== 1'b0 || mm_if.wren !== 1'b0) begin errors++; $display("FAIL fl_q_empty got r%b w%b exp r0 w0", mm_if.rden, mm_if.wren); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_busy got %b exp 1", busy); end
        mm_if.rvalid = 1'b1;
        cyc();
        #2;
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL fl_drop1 got %b exp 0", upd_valid); end
        cyc();
        mm_if.rvalid = 1'b0;
        #2;
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL fl_drop2 got %b exp 0", upd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_idle got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL fl_err got %b exp 0", err); end
    endtask

    task automatic test_flush_presented();
        set_req(1'b1, 1'b0, 32'h4000, '0, '0);
        cyc();
        clear_req();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #2;
        checks++; if (mm_if.rden !== 1'b1 || mm_if.addr !== 32'h4000) begin errors++; $display("FAIL fp_kept got %b/%h exp 1/4000", mm_if.rden, mm_if.addr); end
        mm_if.gnt = 1'b1;
        cyc();
        mm_if.gnt    = 1'b0;
        mm_if.rvalid = 1'b1;
        cyc();
        mm_if.rvalid = 1'b0;
        #2;
        checks++; if (upd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fp_dropped got %b/%b exp 0/0", upd_valid, busy); end
        // rvalid in the flush cycle itself must already be dropped
        set_req(1'b1, 1'b0, 32'h6000, '0, '0);
        cyc();
        clear_req();
        mm_if.gnt = 1'b1;
        cyc();
        mm_if.gnt    = 1'b0;
        mm_if.rvalid = 1'b1;
        flush        = 1'b1;
        cyc();
        mm_if.rvalid = 1'b0;
        flush        = 1'b0;
        #2;
        checks++; if (upd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fp_same_cycle got %b/%b exp 0/0", upd_valid, busy); end
        set_req(1'b1, 1'b0, 32'h7000, '0, '0);
        cyc();
        clear_req();
        mm_if.gnt = 1'b1;
        cyc();
        mm_if.gnt    = 1'b0;
        mm_if.rvalid = 1'b1;
        cyc();
        mm_if.rvalid = 1'b0;
        #2;
        checks++; if (upd_valid !== 1'b1 || upd_addr !== 32'h7000) begin errors++; $display("FAIL fp_after got %b/%h exp 1/7000", upd_valid, upd_addr); end
    endtask

    task automatic test_err();
        logic [LINE_W-1:0] wd;
        wd = mk_line(32'hC000_0000);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mm_if.rvalid = 1'b1;
        cyc();
        mm_if.rvalid = 1'b0;
        #2;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_stray got %b exp 1", err); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL err_no_upd got %b exp 0", upd_valid); end
        set_req(1'b1, 1'b1, 32'h5000, wd, 32'hFFFF_FFFF);
        cyc();
        clear_req();
        #2;
        checks++; if (mm_if.wren !== 1'b1 || mm_if.rden !== 1'b0) begin errors++; $display("FAIL err_as_wr got w%b r%b exp w1 r0", mm_if.wren, mm_if.rden); end
        checks++; if (mm_if.wdata !== wd) begin errors++; $display("FAIL err_wdata got %h exp %h", mm_if.wdata, wd); end
        mm_if.gnt = 1'b1;
        cyc();
        mm_if.gnt = 1'b0;
        #2;
        checks++; if (mm_if.rden !== 1'b0 || mm_if.wren !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_one_wr got r%b w%b b%b exp 0", mm_if.rden, mm_if.wren, busy); end
        cyc();
        #2;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
`ifdef NANOCACHE_REFILL_STATS_EN
        checks++; if (stat_wr !== 32'd1) begin errors++; $display("FAIL stat_wr got %0d exp 1", stat_wr); end
        checks++; if (stat_rd !== 32'd0) begin errors++; $display("FAIL stat_rd got %0d exp 0", stat_rd); end
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #2;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
        // response to a read granted before a reset is a protocol error
        set_req(1'b1, 1'b0, 32'h8000, '0, '0);
        cyc();
        clear_req();
        mm_if.gnt = 1'b1;
        cyc();
        mm_if.gnt = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mm_if.rvalid = 1'b1;
        cyc();
        mm_if.rvalid = 1'b0;
        #2;
        checks++; if (err !== 1'b1 || upd_valid !== 1'b0) begin errors++; $display("FAIL err_post_reset got %b/%b exp 1/0", err, upd_valid); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_outstanding();
        test_wr_then_rd();
        test_flush();
        test_flush_presented();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nanocache_refill.md
# nanocache_refill

Parametrised miss/refill engine sitting between the NanoCore I/D cache miss path and the shared SRAM/memory arbiter. Queues cache-line read (refill) and write (write-back) requests, issues them with a proper grant handshake, tracks up to MAX_OUTST outstanding reads, and returns refill data tagged with its line address. On flush, reads that have not yet been granted are discarded, and responses for already-granted reads are suppressed.

## Interface
- LINE_WORDS, 8, 32-bit words per cache line (≥2)
- ADDR_W, 32, address width
- REQ_DEPTH, 2, request queue entries (power of 2)
- MAX_OUTST, 4, max granted-but-unanswered reads (power of 2)

- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_flush  in  1  pipeline flush pulse
- i_miss_rden  in  1  line refill request
- i_miss_wren  in  1  line write-back request
- i_miss_addr  in  ADDR_W  line address
- i_miss_wdata  in  LINE_WORDS*32  write-back data
- i_miss_wstrb  in  LINE_WORDS*4  byte strobes
- o_miss_ready  out  1  queue can accept this cycle
- o_mm_rden / o_mm_wren  out  1  memory request
- o_mm_addr  out  ADDR_W; o_mm_wdata  out  LINE_WORDS*32; o_mm_wstrb  out  LINE_WORDS*4
- i_mm_gnt  in  1  memory accepted the presented request
- i_mm_rvalid  in  1  read data valid; i_mm_rdata  in  LINE_WORDS*32
- o_upd_valid  out  1  refill line valid (1-cycle pulse)
- o_upd_rdata  out  LINE_WORDS*32; o_upd_addr  out  ADDR_W
- o_busy  out  1  queue non-empty or reads outstanding
- o_err  out  1  sticky protocol error

## Operation
- Accept: request is enqueued when (rden|wren) & o_miss_ready. o_miss_ready = ~queue_full; no same-cycle bypass.
- rden & wren together: the request is enqueued as a write, the read is dropped, and o_err is set.
- Issue: the queue head drives o_mm_*. The request is held stable until i_mm_gnt, then popped.
- A read head is not presented while outstanding == MAX_OUTST. A write head is always presented.
- In-order only: a blocked read also blocks any write behind it.
- Outstanding tracker: FIFO of {addr, drop}. Granted read pushes {addr, 0}. Each i_mm_rvalid pops one entry. If drop==0, o_upd_valid, o_upd_rdata and o_upd_addr are registered.
- Flush:
  - Every queued read not currently presented is removed.
  - A read already presented on o_mm_rden stays until granted, then is pushed with drop=1.
  - All tracker entries get drop=1.
  - Queued writes are never discarded.
- Same-cycle grant + rvalid: push and pop together; count unchanged.
- i_mm_rvalid with an empty tracker: ignored, o_err set.
- o_err clears only on reset.

## Timing
- Reset: all outputs 0; o_miss_ready=1; queue and tracker empty.
- Accept at cycle N → earliest o_mm_* at N+1.
- Grant at N → next head presented at N+1.
- i_mm_rvalid at M → o_upd_valid at M+1; data is taken from i_mm_rdata at M.
- Flush at cycle F:
  - Takes effect on state at F+1.
  - A rvalid in cycle F already pops an entry with drop=1 (drop marking is combinational into the pop decision).
- Reset mid-transfer: all state is abandoned. Responses arriving after reset are protocol errors and set o_err.

## Configuration
- NANOCACHE_REFILL_STATS_EN
- Defined: adds outputs o_stat_rd (32b), o_stat_wr (32b) and o_stat_drop (32b).
  - o_stat_rd counts granted reads, o_stat_wr counts granted writes, o_stat_drop counts suppressed responses.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package nanocache_pkg holds:
  - LINE_W = LINE_WORDS*32.
  - typedef refill_req_t {wr, addr, wdata, wstrb}.
  - typedef outst_t {addr, drop}.
- Sub-module nanocache_sync_fifo: generic synchronous FIFO with push, pop, full, empty, count, plus a per-entry "kill" mask input used for flush. It is instantiated twice: request queue and tracker.

## Test plan
- Single read 0x1000, gnt at +1, rvalid 3 cycles after grant → o_upd_valid one cycle after rvalid, o_upd_addr=0x1000, data matches.
- Four reads with gnt held high and no rvalid (MAX_OUTST=4) → fifth read stays queued with o_mm_rden=0. First rvalid → fifth read presented next cycle.
- Write 0x2000 then read 0x2000 → o_mm_wren first; read only presented after write gnt. Order preserved.
- Two reads granted plus one queued, then flush → queued read vanishes, both rvalids produce no o_upd_valid, o_busy falls after last rvalid.
- Write queued and flush asserted → write still issued with original wdata/wstrb.
- rvalid with idle tracker, then rden&wren together → o_err=1, no o_upd_valid, exactly one write issued; with STATS_EN, o_stat_wr=1.
